// File: rtl/hilo_unit_if.sv
// HI/LO stage bus: op issue, multiplier result and architectural HI/LO.
// master = pipeline/multiplier side, slave = hilo_unit.
interface hilo_unit_if;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] mt_data;
   logic        mlt_halt;
   logic [63:0] prod;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output op_valid, op, mt_data, mlt_halt, prod,
      input  busy, hi, lo
   );

   modport slave (
      input  op_valid, op, mt_data, mlt_halt, prod,
      output busy, hi, lo
   );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register stage after the 2-cycle multiplier.
// Optional MADD/MSUB accumulate enabled by defining HILO_MADD_EN.
module hilo_unit (
   input logic      clk,
   input logic      reset,
   hilo_unit_if.slave bus
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_MUL = 2'd1;
   localparam logic [1:0] ACCUM    = 2'd2;

   localparam logic [2:0] OP_MUL  = 3'd0;
   localparam logic [2:0] OP_MADD = 3'd1;
   localparam logic [2:0] OP_MSUB = 3'd2;
   localparam logic [2:0] OP_MTHI = 3'd3;
   localparam logic [2:0] OP_MTLO = 3'd4;

   logic [1:0]  state;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        is_mul;
   logic        is_acc;

`ifdef HILO_MADD_EN
   logic [2:0]  op_q;
   logic [63:0] prod_q;
   logic [63:0] acc_res;
`endif

   assign is_mul = (bus.op == OP_MUL);

`ifdef HILO_MADD_EN
   assign is_acc = (bus.op == OP_MADD) || (bus.op == OP_MSUB);
`else
   assign is_acc = 1'b0;
`endif

`ifdef HILO_MADD_EN
   // Accumulate result: modulo 2^64, carry/borrow dropped
   always_comb begin
      acc_res = {hi_q, lo_q} + prod_q;
      if (op_q == OP_MSUB)
         acc_res = {hi_q, lo_q} - prod_q;
   end
`endif

   // HI/LO state machine; ops arriving while busy are dropped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         hi_q  <= '0;
         lo_q  <= '0;
`ifdef HILO_MADD_EN
         op_q   <= OP_MUL;
         prod_q <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.op_valid) begin
                  if (bus.op == OP_MTHI)
                     hi_q <= bus.mt_data;
                  else if (bus.op == OP_MTLO)
                     lo_q <= bus.mt_data;
                  else if (is_mul || is_acc) begin
`ifdef HILO_MADD_EN
                     op_q <= bus.op;
`endif
                     state <= WAIT_MUL;
                  end
               end
            end
            WAIT_MUL: begin
               if (!bus.mlt_halt) begin
`ifdef HILO_MADD_EN
                  if (op_q == OP_MUL) begin
                     {hi_q, lo_q} <= bus.prod;
                     state        <= IDLE;
                  end else begin
                     prod_q <= bus.prod;
                     state  <= ACCUM;
                  end
`else
                  {hi_q, lo_q} <= bus.prod;
                  state        <= IDLE;
`endif
               end
            end
`ifdef HILO_MADD_EN
            ACCUM: begin
               {hi_q, lo_q} <= acc_res;
               state        <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed table, corner sequences,
// and random ops against a behavioural HI/LO model.
module tb_hilo_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   hilo_unit_if bus ();

   hilo_unit dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic [63:0] acc;
      bit          pend;
      bit          got;
      logic [2:0]  kind;
      logic [63:0] pq;
   } mdl_t;

   mdl_t mdl;

   // One architectural step of the HI/LO pair from the op semantics
   function automatic mdl_t step(mdl_t m, logic ov, logic [2:0] op,
                                 logic [31:0] mt, logic halt,
                                 logic [63:0] p);
      mdl_t n = m;
      bit madd = 1'b0;
`ifdef HILO_MADD_EN
      madd = 1'b1;
`endif
      if (!m.pend) begin
         if (ov) begin
            if (op == 3'd3) n.acc = {mt, m.acc[31:0]};
            else if (op == 3'd4) n.acc = {m.acc[63:32], mt};
            else if (op == 3'd0 || (madd && (op == 3'd1 || op == 3'd2))) begin
               n.pend = 1'b1;
               n.got = 1'b0;
               n.kind = op;
            end
         end
      end else if (!m.got) begin
         if (!halt) begin
            if (m.kind == 3'd0) begin
               n.acc = p;
               n.pend = 1'b0;
            end else begin
               n.pq = p;
               n.got = 1'b1;
            end
         end
      end else begin
         n.acc = (m.kind == 3'd1) ? m.acc + m.pq : m.acc - m.pq;
         n.pend = 1'b0;
         n.got = 1'b0;
      end
      return n;
   endfunction

   // Reference model tracks the DUT clock-for-clock
   always @(posedge clk or posedge reset) begin
      if (reset) mdl <= '{64'd0, 1'b0, 1'b0, 3'd0, 64'd0};
      else mdl <= step(mdl, bus.op_valid, bus.op, bus.mt_data,
                       bus.mlt_halt, bus.prod);
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic ov, logic [2:0] op, logic [31:0] mt,
                        logic halt, logic [63:0] p);
      bus.op_valid = ov;
      bus.op = op;
      bus.mt_data = mt;
      bus.mlt_halt = halt;
      bus.prod = p;
   endtask

   task automatic expect_out(string tag, logic [31:0] h, logic [31:0] l,
                             logic b);
      check({tag, ".hi"}, {32'd0, bus.hi}, {32'd0, h});
      check({tag, ".lo"}, {32'd0, bus.lo}, {32'd0, l});
      check({tag, ".busy"}, {63'd0, bus.busy}, {63'd0, b});
   endtask

   typedef struct {
      logic        ov;
      logic [2:0]  op;
      logic [31:0] mt;
      logic        halt;
      logic [63:0] prod;
      logic [31:0] ehi;
      logic [31:0] elo;
      logic        ebusy;
   } vec_t;

   vec_t tbl[9];

   initial begin
      tbl[0] = '{1'b1, 3'd3, 32'h5A5A5A5A, 1'b1, 64'h0,
                 32'h5A5A5A5A, 32'h0, 1'b0};
      tbl[1] = '{1'b1, 3'd4, 32'hA5A5A5A5, 1'b1, 64'h0,
                 32'h5A5A5A5A, 32'hA5A5A5A5, 1'b0};
      tbl[2] = '{1'b1, 3'd0, 32'h0, 1'b1, 64'h0,
                 32'h5A5A5A5A, 32'hA5A5A5A5, 1'b1};
      tbl[3] = '{1'b0, 3'd0, 32'h0, 1'b0, 64'h0000_0001_FFFF_FFFE,
                 32'h1, 32'hFFFF_FFFE, 1'b0};
      tbl[4] = '{1'b1, 3'd0, 32'h0, 1'b1, 64'h0,
                 32'h1, 32'hFFFF_FFFE, 1'b1};
      tbl[5] = '{1'b1, 3'd0, 32'h0, 1'b1, 64'h1111_2222_3333_4444,
                 32'h1, 32'hFFFF_FFFE, 1'b1};
      tbl[6] = '{1'b1, 3'd3, 32'h1234, 1'b0, 64'h0000_00AB_0000_00CD,
                 32'hAB, 32'hCD, 1'b0};
      tbl[7] = '{1'b1, 3'd5, 32'hFFFF, 1'b0, 64'hFFFF,
                 32'hAB, 32'hCD, 1'b0};
      tbl[8] = '{1'b0, 3'd3, 32'h9999, 1'b0, 64'h0,
                 32'hAB, 32'hCD, 1'b0};

      drive(1'b0, 3'd0, 32'd0, 1'b1, 64'd0);
      reset = 1'b1;
      tick();
      tick();
      expect_out("reset", 32'h0, 32'h0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].ov, tbl[i].op, tbl[i].mt, tbl[i].halt, tbl[i].prod);
         tick();
         expect_out($sformatf("vec%0d", i), tbl[i].ehi, tbl[i].elo,
                    tbl[i].ebusy);
      end

`ifdef HILO_MADD_EN
      drive(1'b1, 3'd3, 32'hFFFF_FFFF, 1'b1, 64'd0);
      tick();
      drive(1'b1, 3'd4, 32'hFFFF_FFFF, 1'b1, 64'd0);
      tick();
      drive(1'b1, 3'd1, 32'd0, 1'b1, 64'd0);
      tick();
      expect_out("madd.t1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      drive(1'b0, 3'd0, 32'd0, 1'b0, 64'h2);
      tick();
      expect_out("madd.t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      drive(1'b0, 3'd0, 32'd0, 1'b0, 64'h0);
      tick();
      expect_out("madd.t3", 32'h0, 32'h1, 1'b0);

      drive(1'b1, 3'd3, 32'h0, 1'b1, 64'd0);
      tick();
      drive(1'b1, 3'd4, 32'h0, 1'b1, 64'd0);
      tick();
      drive(1'b1, 3'd2, 32'd0, 1'b1, 64'd0);
      tick();
      drive(1'b0, 3'd0, 32'd0, 1'b0, 64'h1);
      tick();
      expect_out("msub.t2", 32'h0, 32'h0, 1'b1);
      drive(1'b0, 3'd0, 32'd0, 1'b0, 64'h0);
      tick();
      expect_out("msub.t3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`else
      drive(1'b1, 3'd1, 32'd0, 1'b0, 64'h55);
      tick();
      expect_out("madd_off", 32'hAB, 32'hCD, 1'b0);
      drive(1'b1, 3'd2, 32'd0, 1'b0, 64'h77);
      tick();
      expect_out("msub_off", 32'hAB, 32'hCD, 1'b0);
      drive(1'b0, 3'd0, 32'd0, 1'b0, 64'h99);
      tick();
      expect_out("off_idle", 32'hAB, 32'hCD, 1'b0);
`endif

      drive(1'b1, 3'd3, 32'hDEAD_BEEF, 1'b1, 64'd0);
      tick();
      drive(1'b1, 3'd0, 32'd0, 1'b1, 64'd0);
      tick();
      check("rst.pre_busy", {63'd0, bus.busy}, 64'd1);
      drive(1'b0, 3'd0, 32'd0, 1'b1, 64'd0);
      #2;
      reset = 1'b1;
      #1;
      expect_out("rst.mid", 32'h0, 32'h0, 1'b0);
      #1;
      reset = 1'b0;
      drive(1'b0, 3'd0, 32'd0, 1'b0, 64'hCAFE_F00D_1234_5678);
      tick();
      tick();
      expect_out("rst.after", 32'h0, 32'h0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         logic ov;
         ov = ($urandom_range(2) != 0);
         if (mdl.pend && ($urandom_range(7) != 0)) ov = 1'b0;
         drive(ov, 3'($urandom_range(7)), $urandom,
               1'($urandom_range(1)), {$urandom, $urandom});
         tick();
         check("rnd.hi", {32'd0, bus.hi}, {32'd0, mdl.acc[63:32]});
         check("rnd.lo", {32'd0, bus.lo}, {32'd0, mdl.acc[31:0]});
         check("rnd.busy", {63'd0, bus.busy}, {63'd0, mdl.pend});
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
